// File: rtl/dw_pkg.sv
// Shared definitions for the dw_initiator two-phase requester: FSM state encoding and
// default parameter values.
package dw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    localparam int DW_SYNC_STAGES = 2;
    localparam int DW_TO_W        = 8;

endpackage

// File: rtl/dw_sync.sv
// N-flop synchronizer for one asynchronous level input, async active-low reset.
// N must be at least 2.
module dw_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/dw_initiator.sv
// Two-phase initiator driving fire/a1/a2 and waiting on asynchronous acknowledges z1/z2.
// Optional acknowledge timeout enabled by defining DW_INIT_TIMEOUT_EN.
module dw_initiator
    import dw_pkg::*;
#(
    parameter int SYNC_STAGES = DW_SYNC_STAGES,
    parameter int TO_W        = DW_TO_W
) (
    input  logic clk,
    input  logic rstn,
    input  logic cmd_valid,
    input  logic cmd_sel,
    output logic cmd_ready,
    output logic done_valid,
    output logic done_sel,
    output logic done_err,
    output logic halted,
    output logic fire,
    output logic a1,
    output logic a2,
    input  logic z1,
    input  logic z2
);

    logic   z1_s, z2_s;
    logic   z1_prev_q, z2_prev_q;
    logic   ev1_q, ev2_q;
    state_e state_q;
    logic   sel_q, fire_q, a1_q, a2_q;
    logic   done_valid_q, done_sel_q, done_err_q, halted_q;
    logic   ev_sel, ev_oth, ev_any;
    logic   timeout, fault, complete;

    dw_sync #(.N(SYNC_STAGES)) u_sync_z1 (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (z1),
        .q_o  (z1_s)
    );

    dw_sync #(.N(SYNC_STAGES)) u_sync_z2 (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (z2),
        .q_o  (z2_s)
    );

    // Each synchronized transition becomes a registered one-cycle event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            z1_prev_q <= 1'b0;
            z2_prev_q <= 1'b0;
            ev1_q     <= 1'b0;
            ev2_q     <= 1'b0;
        end else begin
            z1_prev_q <= z1_s;
            z2_prev_q <= z2_s;
            ev1_q     <= z1_s ^ z1_prev_q;
            ev2_q     <= z2_s ^ z2_prev_q;
        end
    end

    assign ev_sel = sel_q ? ev2_q : ev1_q;
    assign ev_oth = sel_q ? ev1_q : ev2_q;
    assign ev_any = ev1_q | ev2_q;

`ifdef DW_INIT_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;

    assign to_cnt_d = to_cnt_q + 1'b1;
    assign timeout  = (state_q == ST_WAIT) && (&to_cnt_d);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= '0;
        end else if (state_q != ST_WAIT) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_to_w;

    assign timeout     = 1'b0;
    assign unused_to_w = (TO_W > 0);
`endif

    // Any acknowledge that is not the single expected one is a protocol fault.
    always_comb begin
        fault    = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: fault = ev_any;
            ST_WAIT: begin
                complete = ev_sel && !ev_oth;
                fault    = ev_oth || (!ev_sel && timeout);
            end
            ST_DONE: fault = ev_any;
            default: fault = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            fire_q       <= 1'b0;
            a1_q         <= 1'b0;
            a2_q         <= 1'b0;
            done_valid_q <= 1'b0;
            done_sel_q   <= 1'b0;
            done_err_q   <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            done_valid_q <= 1'b0;
            if (fault) begin
                state_q      <= ST_HALT;
                halted_q     <= 1'b1;
                done_valid_q <= 1'b1;
                done_err_q   <= 1'b1;
                done_sel_q   <= sel_q;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            sel_q   <= cmd_sel;
                            fire_q  <= ~fire_q;
                            if (cmd_sel) begin
                                a2_q <= ~a2_q;
                            end else begin
                                a1_q <= ~a1_q;
                            end
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (complete) begin
                            state_q      <= ST_DONE;
                            done_valid_q <= 1'b1;
                            done_err_q   <= 1'b0;
                            done_sel_q   <= sel_q;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_HALT;
                endcase
            end
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign done_valid = done_valid_q;
    assign done_sel   = done_sel_q;
    assign done_err   = done_err_q;
    assign halted     = halted_q;
    assign fire       = fire_q;
    assign a1         = a1_q;
    assign a2         = a2_q;

endmodule

// File: doc/dw_initiator.md
DW_INITIATOR -- requirements
Module: dw_initiator

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in each z-input synchronizer; minimum 2.
REQ-002 Parameter TO_W, default 8: width of the acknowledge-timeout counter; used only with DW_INIT_TIMEOUT_EN.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  a command is offered.
REQ-007 cmd_sel  in  1  0 = request branch 1 (a1/z1); 1 = request branch 2 (a2/z2).
REQ-008 cmd_ready  out  1  block accepts a command this cycle.
REQ-009 done_valid  out  1  one-cycle completion pulse.
REQ-010 done_sel  out  1  branch that completed; valid with done_valid.
REQ-011 done_err  out  1  completion was abnormal; valid with done_valid.
REQ-012 halted  out  1  sticky protocol-fault indicator.
REQ-013 fire  out  1  two-phase fire event to the decision-wait; each transition is one event.
REQ-014 a1, a2  out  1 each  two-phase branch requests; mutually exclusive events.
REQ-015 z1, z2  in  1 each  two-phase branch acknowledges; asynchronous, each transition is one event.

Function
REQ-016 FSM states: IDLE, WAIT, DONE, HALT.
REQ-017 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, latch cmd_sel, toggle fire and toggle a1 (sel=0) or a2 (sel=1) in the same edge, then go to WAIT.
REQ-018 fire, a1 and a2 SHALL be driven directly from flops, with no glitching; the non-selected request SHALL NOT toggle.
REQ-019 Edge detection: z1 and z2 each pass through SYNC_STAGES flops; an event is synchronized value != previous synchronized value.
REQ-020 WAIT: an event on the selected z SHALL move to DONE; an event on the non-selected z SHALL move to HALT.
REQ-021 Simultaneous events on both z in one cycle SHALL be treated as a fault and SHALL move to HALT.
REQ-022 DONE: done_valid=1 and done_err=0 for exactly one cycle; done_sel = latched sel; return to IDLE. cmd_ready=0 in DONE.
REQ-023 Latency: from the accept edge to done_valid is 1 + SYNC_STAGES + 1 cycles plus external response delay; back-to-back throughput is at most one command per SYNC_STAGES+3 cycles.
REQ-024 Any z event observed while in IDLE or DONE SHALL move to HALT.
REQ-025 Entering HALT SHALL pulse done_valid with done_err=1 (done_sel = latched sel) and set halted=1.
REQ-026 HALT: cmd_ready=0; fire, a1 and a2 held; the block leaves HALT only on reset.

Reset
REQ-027 With rstn low: state=IDLE; fire, a1, a2, done_valid, done_sel, done_err and halted =0; all synchronizer and edge flops =0; timeout counter =0.
REQ-028 Reset mid-transaction SHALL abandon the transaction without a completion pulse; the attached decision-wait SHALL share rstn so that both ends restart at phase 0.
REQ-029 Reset deassertion SHALL be synchronized externally; the block does not add a reset synchronizer.

Configuration
REQ-030 Macro DW_INIT_TIMEOUT_EN: when defined, a TO_W-bit counter clears on entry to WAIT and increments each cycle in WAIT; at all-ones, go to HALT with the done_err pulse.
REQ-031 Without DW_INIT_TIMEOUT_EN: no counter is instantiated, and WAIT waits indefinitely.

Structure
REQ-032 Shared package dw_pkg: FSM state encoding constants and the default SYNC_STAGES and TO_W values.
REQ-033 One sub-module, dw_sync (parameterised N-flop synchronizer with async active-low reset), SHALL be instantiated once for z1 and once for z2.

Verification
REQ-034 Normal branch 1: cmd_valid=1, cmd_sel=0 -> fire and a1 toggle 0->1; model toggles z1 -> done_valid pulse with done_sel=0, done_err=0, 4 cycles after the z1 change is sampled (SYNC_STAGES=2).
REQ-035 Alternating branches: 4 commands with sel=0,1,0,1 -> fire ends at 0, a1 ends at 0, a2 ends at 0; 4 clean completions; a2 never toggles during sel=0.
REQ-036 Wrong branch: sel=0 issued, model toggles z2 -> done_err=1 pulse, halted=1, cmd_ready stays 0 for 20 cycles.
REQ-037 Spurious ack: z1 toggles while in IDLE -> HALT with halted=1; rstn low then high -> all outputs 0 and cmd_ready=1.
REQ-038 Timeout (macro defined, TO_W=4): no ack is given -> done_err pulse 15 cycles after entering WAIT, then halted=1; with the macro undefined, no pulse appears after 1000 cycles.
REQ-039 Reset mid-WAIT: rstn is asserted one cycle after accept -> no done_valid pulse, and fire, a1 and a2 read 0.
